// File: rtl/fft_pkg.sv
// Shared types, constants and the index bit-reversal helper for the FFT
// reorder block.
package fft_pkg;

  localparam int unsigned N_POINTS_DEFAULT = 8;
  localparam int unsigned DATA_W_DEFAULT   = 16;

  // Complex sample at the default component width
  typedef struct packed {
    logic signed [DATA_W_DEFAULT-1:0] re;
    logic signed [DATA_W_DEFAULT-1:0] im;
  } cplx_t;

  // Reverse the low log2n bits of idx; bits above log2n come back as zero
  function automatic logic [31:0] bitrev(input logic [31:0] idx,
                                         input int unsigned log2n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(log2n)) begin
        r[5'(i)] = idx[5'(int'(log2n) - 1 - i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_bank.sv
// One frame bank of the ping-pong reorder buffer: N_POINTS complex words of
// register storage plus the bank's full flag. The writer fills only an empty
// bank and the reader drains only a full one.
module fft_pingpong_bank
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS = N_POINTS_DEFAULT,
  parameter int unsigned DATA_W   = DATA_W_DEFAULT,
  localparam int unsigned LOG2N   = $clog2(N_POINTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [LOG2N-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_re,
  input  logic [DATA_W-1:0] wr_im,
  input  logic              set_full,
  input  logic              clr_full,
  input  logic [LOG2N-1:0]  rd_addr,
  output logic              full,
  output logic [DATA_W-1:0] rd_re,
  output logic [DATA_W-1:0] rd_im
);

  logic [DATA_W-1:0] mem_re [N_POINTS];
  logic [DATA_W-1:0] mem_im [N_POINTS];

  // Sample storage; deliberately not reset, contents are only meaningful once full
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re[wr_addr] <= wr_re;
      mem_im[wr_addr] <= wr_im;
    end
  end

  // Full flag: set when the writer completes this bank, cleared when the reader drains it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (set_full) begin
      full <= 1'b1;
    end else if (clr_full) begin
      full <= 1'b0;
    end
  end

  assign rd_re = mem_re[rd_addr];
  assign rd_im = mem_im[rd_addr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for FFT output frames.
// Two ping-pong banks: one fills in bit-reversed address order while the
// other drains in natural order through a valid/ready stream.
// Optional macro FFT_REORDER_FRAME_CHECK_EN adds in_last and a sticky
// frame_err flag that reports in_last disagreeing with the sample count.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS = N_POINTS_DEFAULT,
  parameter int unsigned DATA_W   = DATA_W_DEFAULT,
  localparam int unsigned LOG2N   = $clog2(N_POINTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
`ifdef FFT_REORDER_FRAME_CHECK_EN
  input  logic              in_last,
  output logic              frame_err,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_last,
  output logic [LOG2N-1:0]  out_idx
);

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

  logic              wr_bank;
  logic              rd_bank;
  logic [LOG2N-1:0]  wr_idx;
  logic [LOG2N-1:0]  rd_idx;
  logic [LOG2N-1:0]  wr_addr;
  logic              wr_last;
  logic              rd_last;
  logic              wr_fire;
  logic              rd_fire;

  logic [1:0]        full;
  logic [1:0]        bank_wr_en;
  logic [1:0]        bank_set;
  logic [1:0]        bank_clr;
  logic [DATA_W-1:0] bank_re [2];
  logic [DATA_W-1:0] bank_im [2];

  assign wr_last   = (wr_idx == LAST_IDX);
  assign rd_last   = (rd_idx == LAST_IDX);
  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_addr   = LOG2N'(bitrev(32'(wr_idx), LOG2N));

  // Two banks; the top routes write/read strobes to the bank each pointer selects
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_wr_en[b] = wr_fire && (wr_bank == 1'(b));
    assign bank_set[b]   = bank_wr_en[b] && wr_last;
    assign bank_clr[b]   = rd_fire && rd_last && (rd_bank == 1'(b));

    fft_pingpong_bank #(
      .N_POINTS (N_POINTS),
      .DATA_W   (DATA_W)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (bank_wr_en[b]),
      .wr_addr  (wr_addr),
      .wr_re    (in_re),
      .wr_im    (in_im),
      .set_full (bank_set[b]),
      .clr_full (bank_clr[b]),
      .rd_addr  (rd_idx),
      .full     (full[b]),
      .rd_re    (bank_re[b]),
      .rd_im    (bank_im[b])
    );
  end

  // Write pointer: advance per accepted sample, hop banks after the frame's last sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
    end else if (wr_fire) begin
      if (wr_last) begin
        wr_bank <= ~wr_bank;
        wr_idx  <= '0;
      end else begin
        wr_idx  <= wr_idx + LOG2N'(1);
      end
    end
  end

  // Read pointer: advance per output handshake, hop banks after out_last is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank <= 1'b0;
      rd_idx  <= '0;
    end else if (rd_fire) begin
      if (rd_last) begin
        rd_bank <= ~rd_bank;
        rd_idx  <= '0;
      end else begin
        rd_idx  <= rd_idx + LOG2N'(1);
      end
    end
  end

  assign out_re   = bank_re[rd_bank];
  assign out_im   = bank_im[rd_bank];
  assign out_idx  = rd_idx;
  assign out_last = out_valid && rd_last;

`ifdef FFT_REORDER_FRAME_CHECK_EN
  // Sticky flag: in_last must coincide exactly with the count-defined final sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if (wr_fire && (in_last != wr_last)) begin
      frame_err <= 1'b1;
    end
  end
`endif

endmodule
